// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter.
// Used by reg_write_arbiter; the optional REG_ARB_LOCK_EN build uses the same types.
package reg_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Pointer advance with wrap at r (r is the requester count).
    function automatic int next_ptr(input int idx, input int r);
        return (idx + 1 >= r) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nbit_reg.sv
// Plain N-bit storage register with synchronous active-high clear and load enable.
module nbit_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo R.
module rr_pick #(
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    always_comb begin
        int sum;
        logic [IW-1:0] idx;
        sum     = 0;
        idx     = '0;
        winner  = '0;
        any_req = |req;
        // Walk from the farthest slot back toward ptr so the closest hit wins.
        for (int k = R - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= R)
                sum = sum - R;
            idx = IW'(sum);
            if (req[idx])
                winner = idx;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one N-bit register among R requesters, one write per grant.
// Define REG_ARB_LOCK_EN to add the `lock` input for back-to-back writes by one owner.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic           lock,
`endif
    output logic [R-1:0]   gnt,
    output logic [N-1:0]   q,
    output logic [IW-1:0]  owner,
    output logic           valid,
    output logic           busy
);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [IW-1:0] winner;
    logic          any_req;
    logic          hold;
    logic          wr_en;
    logic [N-1:0]  wr_data;

    function automatic logic [R-1:0] onehot(input logic [IW-1:0] i);
        logic [R-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_pick #(.R(R)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef REG_ARB_LOCK_EN
    assign hold = lock & req[sel];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < R; i++) begin
            if (sel == IW'(i))
                wr_data = wdata[i*N +: N];
        end
    end

    // The register loads only in WRITE, so data is taken in the grant cycle.
    assign wr_en = (state == WRITE);

    nbit_reg #(.N(N)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .d     (wr_data),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
            ptr   <= '0;
            sel   <= '0;
            owner <= '0;
            valid <= 1'b0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (any_req) begin
                        sel   <= winner;
                        gnt   <= onehot(winner);
                        busy  <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    owner <= sel;
                    valid <= 1'b1;
                    // A held lock keeps the same owner and pointer for another write.
                    if (!hold) begin
                        ptr   <= IW'(next_ptr(int'(sel), R));
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter; exercises the lock path when REG_ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [R-1:0]   req;
    logic [R*N-1:0] wdata;
`ifdef REG_ARB_LOCK_EN
    logic           lock;
`endif
    logic [R-1:0]   gnt;
    logic [N-1:0]   q;
    logic [1:0]     owner;
    logic           valid;
    logic           busy;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
`ifdef REG_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .valid (valid),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_wd(input int i, input logic [7:0] v);
        wdata[i*N +: N] = v;
    endtask

    task automatic push(input int i, input logic [7:0] v);
        exp_t e;
        e.idx  = i;
        e.data = v;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits (bounded) for the next grant, checks it against the scoreboard head,
    // then checks the register contents one cycle later.
    task automatic wait_grant(input string tag, input logic [R-1:0] drop, output int waits);
        exp_t e;
        bit   found;
        waits = 0;
        found = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            waits++;
            if (gnt != '0) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_grant_seen"}, 32'(found), 1);
        if (!found)
            return;
        chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << e.idx));
        chk({tag, "_busy"}, 32'(busy), 1);
        req = req & ~drop;
        @(negedge clk);
        chk({tag, "_q"}, 32'(q), 32'(e.data));
        chk({tag, "_owner"}, 32'(owner), 32'(e.idx));
        chk({tag, "_valid"}, 32'(valid), 1);
        chk({tag, "_gnt_low"}, 32'(gnt), 0);
    endtask

    initial begin
        int w;
        reset = 1'b1;
        req   = '0;
        wdata = '0;
`ifdef REG_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        do_reset(2);

        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single request: grant exactly one cycle after req is sampled.
        @(posedge clk);
        #1;
        set_wd(2, 8'hAA);
        req = 4'b0100;
        push(2, 8'hAA);
        wait_grant("single", 4'b0100, w);
        chk("single_latency", 32'(w), 2);

        // Fairness from a fresh pointer.
        do_reset(1);
        for (int i = 0; i < R; i++)
            set_wd(i, 8'h10 + 8'(i));
        push(0, 8'h10);
        push(1, 8'h11);
        push(2, 8'h12);
        push(3, 8'h13);
        push(0, 8'h10);
        @(posedge clk);
        #1 req = 4'b1111;
        wait_grant("rr0", 4'b0000, w);
        for (int i = 1; i < 4; i++) begin
            wait_grant("rr", 4'b0000, w);
            chk("rr_every_other", 32'(w), 1);
        end
        wait_grant("rr4", 4'b1111, w);
        chk("rr_every_other", 32'(w), 1);

        // Owner 3, then pointer wraps to 0.
        @(posedge clk);
        #1 req = 4'b1000;
        push(3, 8'h13);
        wait_grant("own3", 4'b1000, w);
        @(posedge clk);
        #1 req = 4'b1001;
        push(0, 8'h10);
        push(3, 8'h13);
        wait_grant("wrap0", 4'b0001, w);
        wait_grant("wrap3", 4'b1000, w);

        // Idle: nothing moves.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_q", 32'(q), 32'h13);
            chk("idle_owner", 32'(owner), 3);
        end

        // Reset landing on a WRITE cycle discards the write.
        set_wd(1, 8'h55);
        @(posedge clk);
        #1 req = 4'b0010;
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("midrst_in_write_gnt", 32'(gnt), 32'h2);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_q", 32'(q), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_owner", 32'(owner), 0);
        @(posedge clk);
        #1 req = 4'b1010;
        push(1, 8'h55);
        wait_grant("after_rst", 4'b1010, w);

`ifdef REG_ARB_LOCK_EN
        begin
            exp_t e;
            bit   found;
            found = 1'b0;
            push(0, 8'h01);
            push(0, 8'h02);
            push(0, 8'h03);
            push(1, 8'h55);
            @(posedge clk);
            #1;
            set_wd(0, 8'h01);
            lock = 1'b1;
            req  = 4'b0011;
            e = sb.pop_front();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (gnt != '0) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("lock_grant_seen", 32'(found), 1);
            chk("lock_gnt1", 32'(gnt), 32'(4'b0001 << e.idx));
            @(negedge clk);
            chk("lock_q1", 32'(q), 32'(e.data));
            chk("lock_gnt2", 32'(gnt), 32'h1);
            e = sb.pop_front();
            set_wd(0, 8'h02);
            @(negedge clk);
            chk("lock_q2", 32'(q), 32'(e.data));
            chk("lock_gnt3", 32'(gnt), 32'h1);
            e = sb.pop_front();
            set_wd(0, 8'h03);
            lock = 1'b0;
            req  = 4'b0010;
            @(negedge clk);
            chk("lock_q3", 32'(q), 32'(e.data));
            chk("lock_end_gnt", 32'(gnt), 0);
            wait_grant("lock_next", 4'b0010, w);
            chk("lock_next_latency", 32'(w), 1);
        end
`endif

        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
